// File: rtl/cp0_exc_unit.sv
// CP0 register file and exception controller for the 5-stage MIPS core.
// Prioritises commit-stage exceptions and interrupts, and drives PC redirect and pipeline flush.
module cp0_exc_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'hbfc00380
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       hw_int,
    input  logic             mtc0_we,
    input  logic [4:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [4:0]       raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic             inst_valid,
    input  logic [WIDTH-1:0] pc_i,
    input  logic             in_delayslot,
    input  logic [WIDTH-1:0] bad_addr,
    input  logic             exc_adel_if,
    input  logic             exc_ri,
    input  logic             exc_ov,
    input  logic             exc_sys,
    input  logic             exc_bp,
    input  logic             exc_adel_ld,
    input  logic             exc_ades,
    input  logic             eret_i,
    output logic             exception,
    output logic             eret_o,
    output logic             flush,
    output logic [WIDTH-1:0] new_pc,
    output logic [WIDTH-1:0] epc_o
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_BP   = 5'd9;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_OV   = 5'd12;

    logic [WIDTH-1:0] badvaddr_reg;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] compare_reg;
    logic [WIDTH-1:0] epc_reg;
    logic             tick_reg;
    logic [7:0]       im_reg;
    logic             exl_reg;
    logic             ie_reg;
    logic             bd_reg;
    logic             ti_reg;
    logic [5:0]       ip_hw_reg;
    logic [1:0]       ip_sw_reg;
    logic [4:0]       exccode_reg;

    logic [5:0]       ip_hw_next;
    logic [7:0]       ip;
    logic             int_pending;
    logic             exc_sync;
    logic [4:0]       exc_code;
    logic             bad_from_pc;
    logic             bad_from_addr;
    logic             wr;
    logic             wr_count;
    logic             wr_compare;
    logic             wr_status;
    logic             wr_cause;
    logic             wr_epc;
    logic [31:0]      status_val;
    logic [31:0]      cause_val;

    // The timer interrupt is merged onto hardware line 5 before sampling.
    assign ip_hw_next[5] = hw_int[5] | ti_reg;
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_ip_hw
            assign ip_hw_next[gi] = hw_int[gi];
        end
    endgenerate

    assign ip          = {ip_hw_reg, ip_sw_reg};
    assign int_pending = ie_reg & ~exl_reg & (|(ip & im_reg));

    always_comb begin
        exc_code      = CODE_INT;
        exc_sync      = 1'b0;
        bad_from_pc   = 1'b0;
        bad_from_addr = 1'b0;
        if (int_pending) begin
            exc_code = CODE_INT;
        end else if (inst_valid) begin
            if (exc_adel_if) begin
                exc_code    = CODE_ADEL;
                exc_sync    = 1'b1;
                bad_from_pc = 1'b1;
            end else if (exc_ri) begin
                exc_code = CODE_RI;
                exc_sync = 1'b1;
            end else if (exc_ov) begin
                exc_code = CODE_OV;
                exc_sync = 1'b1;
            end else if (exc_sys) begin
                exc_code = CODE_SYS;
                exc_sync = 1'b1;
            end else if (exc_bp) begin
                exc_code = CODE_BP;
                exc_sync = 1'b1;
            end else if (exc_adel_ld) begin
                exc_code      = CODE_ADEL;
                exc_sync      = 1'b1;
                bad_from_addr = 1'b1;
            end else if (exc_ades) begin
                exc_code      = CODE_ADES;
                exc_sync      = 1'b1;
                bad_from_addr = 1'b1;
            end
        end
    end

    assign exception = int_pending | exc_sync;
    assign eret_o    = inst_valid & eret_i & ~exception;
    assign flush     = exception | eret_o;
    assign new_pc    = exception ? EXC_VECTOR : epc_reg;
    assign epc_o     = epc_reg;

    // A faulting instruction never commits its MTC0; ERET also blocks a same-cycle EPC write.
    assign wr         = mtc0_we & ~exception;
    assign wr_count   = wr && (waddr == REG_COUNT);
    assign wr_compare = wr && (waddr == REG_COMPARE);
    assign wr_status  = wr && (waddr == REG_STATUS);
    assign wr_cause   = wr && (waddr == REG_CAUSE);
    assign wr_epc     = wr && (waddr == REG_EPC) && !eret_o;

    assign status_val = {9'd0, 1'b1, 6'd0, im_reg, 6'd0, exl_reg, ie_reg};
    assign cause_val  = {bd_reg, ti_reg, 14'd0, ip, 1'b0, exccode_reg, 2'b00};

    always_comb begin
        rdata = '0;
        case (raddr)
            REG_BADVADDR: rdata = badvaddr_reg;
            REG_COUNT:    rdata = count_reg;
            REG_COMPARE:  rdata = compare_reg;
            REG_STATUS:   rdata = status_val;
            REG_CAUSE:    rdata = cause_val;
            REG_EPC:      rdata = epc_reg;
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            badvaddr_reg <= '0;
            count_reg    <= '0;
            compare_reg  <= '0;
            epc_reg      <= '0;
            tick_reg     <= 1'b0;
            im_reg       <= '0;
            exl_reg      <= 1'b0;
            ie_reg       <= 1'b0;
            bd_reg       <= 1'b0;
            ti_reg       <= 1'b0;
            ip_hw_reg    <= '0;
            ip_sw_reg    <= '0;
            exccode_reg  <= '0;
        end else begin
            tick_reg  <= ~tick_reg;
            ip_hw_reg <= ip_hw_next;

            if (wr_count)
                count_reg <= wdata;
            else
                count_reg <= count_reg + {{(WIDTH-1){1'b0}}, tick_reg};

            if (wr_compare)
                compare_reg <= wdata;

            if (wr_compare)
                ti_reg <= 1'b0;
            else if ((count_reg == compare_reg) && (compare_reg != '0))
                ti_reg <= 1'b1;

            if (wr_cause)
                ip_sw_reg <= wdata[9:8];

            if (exception) begin
                exl_reg     <= 1'b1;
                exccode_reg <= exc_code;
                // Nested exceptions keep the original return address.
                if (!exl_reg) begin
                    epc_reg <= in_delayslot ? (pc_i - WIDTH'(4)) : pc_i;
                    bd_reg  <= in_delayslot;
                end
                if (bad_from_pc)
                    badvaddr_reg <= pc_i;
                else if (bad_from_addr)
                    badvaddr_reg <= bad_addr;
            end else begin
                if (wr_status) begin
                    im_reg  <= wdata[15:8];
                    exl_reg <= wdata[1];
                    ie_reg  <= wdata[0];
                end
                if (eret_o)
                    exl_reg <= 1'b0;
                if (wr_epc)
                    epc_reg <= wdata;
            end
        end
    end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 register file and exception controller for the 5-stage MIPS core.
- Sits at the MEM/commit stage. Collects exception flags, interrupts and ERET from the committing instruction, and updates BadVAddr/Count/Compare/Status/Cause/EPC.
- Drives the PC register's exception, eret and epc inputs, and the pipeline flush.

Parameters:
- WIDTH, 32, data/address width. Fixed at 32 for the core; present for port sizing only.
- EXC_VECTOR, 32'hbfc00380, general exception entry address driven on new_pc.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  asynchronous, active-low reset.
- hw_int  input  6  external hardware interrupt lines, level-sensitive.
- mtc0_we  input  1  MTC0 write enable from the committing instruction.
- waddr  input  5  CP0 register number for MTC0.
- wdata  input  WIDTH  MTC0 write data.
- raddr  input  5  CP0 register number for MFC0.
- rdata  output  WIDTH  combinational read of the addressed register; 0 for unimplemented registers.
- inst_valid  input  1  a real instruction occupies the commit stage. All exceptions except interrupt require it.
- pc_i  input  WIDTH  PC of the committing instruction.
- in_delayslot  input  1  committing instruction is in a branch delay slot.
- bad_addr  input  WIDTH  faulting data address for load/store address errors.
- exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_ld, exc_ades  input  1 each  exception flags.
- eret_i  input  1  committing instruction is ERET.
- exception  output  1  combinational; an exception is taken this cycle.
- eret_o  output  1  combinational; ERET is taken this cycle.
- flush  output  1  exception OR eret_o.
- new_pc  output  WIDTH  EXC_VECTOR when exception, else EPC.
- epc_o  output  WIDTH  current EPC register value.

Behaviour:
- Reset values (async, rst=0):
  - Status = 32'h0040_0000 (BEV=1, IE=0, EXL=0).
  - Cause = 0, EPC = 0, BadVAddr = 0, Count = 0, Compare = 0.
  - Internal tick = 0.
  - All combinational outputs follow from these values.
- Register map:
  - 8 BadVAddr: read-only.
  - 9 Count: R/W.
  - 11 Compare: R/W.
  - 12 Status: writable IM[15:8], EXL[1], IE[0]; BEV[22] read-only 1; other bits 0.
  - 13 Cause: writable IP[9:8] only; BD[31], TI[30], IP[15:10], ExcCode[6:2] hardware-set.
  - 14 EPC: R/W.
- Count: tick toggles every cycle; Count increments when tick=1, i.e. +1 every 2 cycles, wrapping 32'hffffffff -> 0. An MTC0 to Count overrides the increment that cycle.
- Timer:
  - TI sets on the cycle after Count == Compare (and Compare != 0).
  - An MTC0 to Compare clears TI.
- IP[15:10] is registered each cycle as {hw_int[5] | TI, hw_int[4:0]}.
- Interrupt pending = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- exception asserts if interrupt pending, or if inst_valid and any exception flag is set.
- Priority and ExcCode, highest first:
  - Int (0)
  - AdEL-fetch (4)
  - RI (10)
  - Ov (12)
  - Sys (8)
  - Bp (9)
  - AdEL-load (4)
  - AdES (5)
- On exception, at the clock edge:
  - If EXL=0: EPC <= in_delayslot ? pc_i-4 : pc_i, and Cause.BD <= in_delayslot.
  - If EXL=1: EPC and BD are unchanged.
  - EXL <= 1.
  - ExcCode is updated.
  - BadVAddr <= pc_i for AdEL-fetch, or <= bad_addr for AdEL-load/AdES; otherwise unchanged.
- ERET:
  - eret_o = inst_valid & eret_i & ~exception.
  - On the edge: EXL <= 0.
  - new_pc = EPC, using the pre-edge value.
- Collisions:
  - MTC0 in the same cycle as an exception is suppressed; the faulting instruction does not commit.
  - MTC0 to EPC in the same cycle as ERET is suppressed; new_pc uses the old EPC.
- Read-after-write: rdata shows the old value in the write cycle and the new value the following cycle. There is no internal bypass.
- rst deasserted mid-operation: state resumes from the reset values on the first posedge after release.

Test Plan:
- Reset, then read reg 12 and reg 13 -> rdata 32'h00400000 and 0. Write Count=5; after 4 cycles Count reads 7.
- Compare=10, Count=8, Status IM7=1, IE=1 -> TI sets after Count reaches 10. exception=1, new_pc=32'hbfc00380, ExcCode=0, EXL=1. Then write Compare=20 -> TI=0.
- pc_i=32'hbfc00104, in_delayslot=1, exc_ov=1, exc_sys=1 -> ExcCode=12, EPC=32'hbfc00100, BD=1, flush=1.
- exc_ades, bad_addr=32'h00000003 -> BadVAddr=3, ExcCode=5. Then eret_i=1 -> eret_o=1, new_pc=EPC, EXL=0 next cycle.
- With EXL=1, exc_sys at pc_i=32'h80000010 -> EPC unchanged, ExcCode=8. An MTC0 to EPC in the same cycle has no effect.
- Assert rst low mid-sequence with EXL=1 and Count=100 -> immediately Status=32'h00400000 and Count=0, with no clock edge required.
